// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store port: one request in flight,
// fixed wait latency, byte-lane merged stores, full-word loads, error flagging.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    funct3_q, funct3_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic          op_we;
  logic [31:0]   op_addr;
  logic [31:0]   op_wdata;
  logic [2:0]    op_f3;
  logic [AW-1:0] op_idx;
  logic          op_err;
  logic          f3_ok;
  logic          misaligned;
  logic          out_of_range;
  logic          commit;
  logic          mem_we;
  logic [3:0]    be;
  logic [31:0]   lane;
  logic [31:0]   rsp_rdata_n;

  // The operation is taken from the live request in IDLE so a single-cycle
  // latency can commit on the acceptance edge; otherwise from the latched copy.
  always_comb begin
    op_we    = (state_q == IDLE) ? req_we     : we_q;
    op_addr  = (state_q == IDLE) ? req_addr   : addr_q;
    op_wdata = (state_q == IDLE) ? req_wdata  : wdata_q;
    op_f3    = (state_q == IDLE) ? req_funct3 : funct3_q;
    op_idx   = op_addr[AW+1:2];

    if (op_we) f3_ok = op_f3 inside {3'b000, 3'b001, 3'b010};
    else       f3_ok = op_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    misaligned   = ((op_f3[1:0] == 2'b01) && op_addr[0]) ||
                   ((op_f3[1:0] == 2'b10) && (op_addr[1:0] != 2'b00));
    out_of_range = {2'b00, op_addr[31:2]} >= DEPTH_WORDS;
    op_err       = misaligned || !f3_ok || out_of_range;

    unique case (op_f3[1:0])
      2'b00: begin
        be   = 4'b0001 << op_addr[1:0];
        lane = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        be   = 4'b0011 << {op_addr[1], 1'b0};
        lane = {2{op_wdata[15:0]}};
      end
      default: begin
        be   = 4'b1111;
        lane = op_wdata;
      end
    endcase

    commit = ((state_q == WAIT) && (cnt_q == '0)) ||
             ((LATENCY == 1) && (state_q == IDLE) && req_valid);
    mem_we = commit && op_we && !op_err && !reset;

    rsp_rdata_n = (op_err || op_we) ? '0 : mem[op_idx];
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[op_idx][8*b +: 8] <= lane[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    funct3_d    = funct3_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d        = req_we;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          funct3_d    = req_funct3;
          req_ready_d = 1'b0;
          if (LATENCY == 1) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = rsp_rdata_n;
            rsp_err_d   = op_err;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rsp_rdata_n;
          rsp_err_d   = op_err;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      funct3_q    <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      funct3_q    <= funct3_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Table-driven bench for dmem_responder with a response scoreboard queue.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_funct3(req_funct3),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with the responder back in IDLE.
  task automatic run_req(input vec_t v, input int stall);
    exp_t e;
    exp_t got;
    int   k;
    logic [31:0] held_rdata;
    logic        held_err;
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    req_funct3 = v.f3;
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    sb_q.push_back(e);
    @(posedge clk);
    k = 0;
    while (1) begin
      @(negedge clk);
      if (k == 0) begin
        req_valid  = 1'b0;
        req_we     = ~req_we;
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_funct3 = 3'($urandom);
      end
      if (rsp_valid || k >= 20) break;
      @(posedge clk);
      k++;
    end
    chk("rsp_valid_seen", {31'b0, rsp_valid}, 32'd1);
    chk("latency", 32'(k), 32'(LAT));
    got = sb_q.pop_front();
    chk("rsp_rdata", rsp_rdata, got.rdata);
    chk("rsp_err", {31'b0, rsp_err}, {31'b0, got.err});
    chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
    held_rdata = got.rdata;
    held_err   = got.err;
    for (int s = 0; s < stall; s++) begin
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_addr   = 32'h10;
      req_wdata  = 32'h0;
      req_funct3 = 3'b010;
      @(posedge clk);
      @(negedge clk);
      chk("stall_valid", {31'b0, rsp_valid}, 32'd1);
      chk("stall_rdata", rsp_rdata, held_rdata);
      chk("stall_err", {31'b0, rsp_err}, {31'b0, held_err});
      chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", {31'b0, rsp_valid}, 32'd0);
    chk("req_ready_back", {31'b0, req_ready}, 32'd1);
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [2:0] f3, input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.f3 = f3;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_funct3 = '0;
    rsp_ready  = 1'b0;

    tbl.push_back(mk(1'b1, 32'h10,  32'hDEADBEEF, 3'b010, 32'h0,        1'b0)); // SW
    tbl.push_back(mk(1'b0, 32'h10,  32'h0,        3'b010, 32'hDEADBEEF, 1'b0)); // LW
    tbl.push_back(mk(1'b1, 32'h11,  32'h000000AA, 3'b000, 32'h0,        1'b0)); // SB
    tbl.push_back(mk(1'b1, 32'h12,  32'h00001234, 3'b001, 32'h0,        1'b0)); // SH
    tbl.push_back(mk(1'b0, 32'h10,  32'h0,        3'b010, 32'h1234AAEF, 1'b0));
    tbl.push_back(mk(1'b1, 32'h13,  32'hFFFFFFFF, 3'b001, 32'h0,        1'b1)); // SH misaligned
    tbl.push_back(mk(1'b0, 32'h02,  32'h0,        3'b010, 32'h0,        1'b1)); // LW misaligned
    tbl.push_back(mk(1'b0, 32'h01,  32'h0,        3'b001, 32'h0,        1'b1)); // LH misaligned
    tbl.push_back(mk(1'b0, 32'h10,  32'h0,        3'b010, 32'h1234AAEF, 1'b0));
    tbl.push_back(mk(1'b0, DEPTH*4, 32'h0,        3'b010, 32'h0,        1'b1)); // out of range
    tbl.push_back(mk(1'b1, 32'h10,  32'hFFFFFFFF, 3'b011, 32'h0,        1'b1)); // bad store f3
    tbl.push_back(mk(1'b1, 32'h10,  32'hFFFFFFFF, 3'b100, 32'h0,        1'b1)); // bad store f3
    tbl.push_back(mk(1'b0, 32'h10,  32'h0,        3'b110, 32'h0,        1'b1)); // bad load f3
    tbl.push_back(mk(1'b0, 32'h10,  32'h0,        3'b010, 32'h1234AAEF, 1'b0));
    tbl.push_back(mk(1'b0, 32'h13,  32'h0,        3'b100, 32'h1234AAEF, 1'b0)); // LBU word
    tbl.push_back(mk(1'b0, 32'h12,  32'h0,        3'b101, 32'h1234AAEF, 1'b0)); // LHU word
    tbl.push_back(mk(1'b1, DEPTH*4-4, 32'hCAFEF00D, 3'b010, 32'h0,      1'b0)); // last word
    tbl.push_back(mk(1'b1, DEPTH*4-1, 32'h12345677, 3'b000, 32'h0,      1'b0));
    tbl.push_back(mk(1'b0, DEPTH*4-4, 32'h0,      3'b010, 32'h77FEF00D, 1'b0));
    tbl.push_back(mk(1'b1, 32'h20,  32'h0,        3'b010, 32'h0,        1'b0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) run_req(tbl[i], 0);

    // Backpressure with an intruding store presented during the stall.
    run_req(mk(1'b0, 32'h10, 32'h0, 3'b010, 32'h1234AAEF, 1'b0), 5);
    run_req(mk(1'b0, 32'h10, 32'h0, 3'b010, 32'h1234AAEF, 1'b0), 0);
    run_req(mk(1'b1, 32'h13, 32'h0, 3'b010, 32'h0, 1'b1), 3);

    // Reset on the would-be commit edge of a store.
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr   = 32'h20;
    req_wdata  = 32'h11111111;
    req_funct3 = 3'b010;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_wait_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_wait_req_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    run_req(mk(1'b0, 32'h20, 32'h0, 3'b010, 32'h0, 1'b0), 0);

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
